// File: rtl/dma_seq_pkg.sv
// ============================================================================
// dma_seq_pkg : shared width, state encodings and address helper for dma_seq
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dma_seq_pkg;

  localparam int CPU_W = 16;

  typedef logic [CPU_W-1:0] word_t;

  localparam logic [1:0] DMA_IDLE = 2'd0;
  localparam logic [1:0] DMA_RUN  = 2'd1;
  localparam logic [1:0] DMA_DONE = 2'd2;

  // Address arithmetic wraps modulo 2^CPU_W by construction of the width.
  function automatic word_t next_addr(input word_t addr, input word_t stride);
    return addr + stride;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dma_chan.sv
// ============================================================================
// dma_chan : one load/store address channel (FSM, addr/count/stride, req/done)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_chan
  import dma_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [CPU_W-1:0] i_sa,
  input  logic [CPU_W-1:0] i_dnum,
  input  logic [CPU_W-1:0] i_stride,
  input  logic             i_gnt,
  output logic             o_req,
  output logic [CPU_W-1:0] o_addr,
  output logic             o_done,
  output logic             o_busy
);

  logic [1:0] state_q, state_d;
  word_t      addr_q, addr_d;
  word_t      count_q, count_d;
  word_t      stride_q, stride_d;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    count_d  = count_q;
    stride_d = stride_q;
    case (state_q)
      DMA_IDLE, DMA_DONE: begin
        // A start in the DONE cycle chains straight into the next sequence.
        if (i_start) begin
          addr_d   = i_sa;
          count_d  = i_dnum;
          stride_d = i_stride;
          state_d  = (i_dnum == '0) ? DMA_DONE : DMA_RUN;
        end else begin
          state_d  = DMA_IDLE;
        end
      end
      DMA_RUN: begin
        if (i_gnt) begin
          addr_d  = next_addr(addr_q, stride_q);
          count_d = count_q - word_t'(1);
          if (count_q == word_t'(1)) state_d = DMA_DONE;
        end
      end
      default: state_d = DMA_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= DMA_IDLE;
      addr_q   <= '0;
      count_q  <= '0;
      stride_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      stride_q <= stride_d;
    end
  end

  assign o_req  = (state_q == DMA_RUN);
  assign o_busy = (state_q == DMA_RUN);
  assign o_done = (state_q == DMA_DONE);
  assign o_addr = addr_q;

endmodule

`default_nettype wire

// File: rtl/dma_seq.sv
// ============================================================================
// dma_seq : independent load and store address sequencers with req/gnt ports
//           DMA_STRIDE_EN adds per-channel stride inputs (default stride 1)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_seq
  import dma_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start_ld,
  input  logic [CPU_W-1:0] i_sa_ld,
  input  logic [CPU_W-1:0] i_dnum_ld,
  input  logic             i_start_st,
  input  logic [CPU_W-1:0] i_sa_st,
  input  logic [CPU_W-1:0] i_dnum_st,
  output logic             o_ld_req,
  output logic [CPU_W-1:0] o_ld_addr,
  input  logic             i_ld_gnt,
  output logic             o_st_req,
  output logic [CPU_W-1:0] o_st_addr,
  input  logic             i_st_gnt,
  output logic             o_ld_done,
  output logic             o_st_done,
`ifdef DMA_STRIDE_EN
  input  logic [CPU_W-1:0] i_stride_ld,
  input  logic [CPU_W-1:0] i_stride_st,
`endif
  output logic             o_busy
);

  word_t ld_stride, st_stride;
  logic  ld_busy, st_busy;

`ifdef DMA_STRIDE_EN
  assign ld_stride = i_stride_ld;
  assign st_stride = i_stride_st;
`else
  assign ld_stride = word_t'(1);
  assign st_stride = word_t'(1);
`endif

  dma_chan u_ld (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (i_start_ld),
    .i_sa     (i_sa_ld),
    .i_dnum   (i_dnum_ld),
    .i_stride (ld_stride),
    .i_gnt    (i_ld_gnt),
    .o_req    (o_ld_req),
    .o_addr   (o_ld_addr),
    .o_done   (o_ld_done),
    .o_busy   (ld_busy)
  );

  dma_chan u_st (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (i_start_st),
    .i_sa     (i_sa_st),
    .i_dnum   (i_dnum_st),
    .i_stride (st_stride),
    .i_gnt    (i_st_gnt),
    .o_req    (o_st_req),
    .o_addr   (o_st_addr),
    .o_done   (o_st_done),
    .o_busy   (st_busy)
  );

  assign o_busy = ld_busy | st_busy;

endmodule

`default_nettype wire

// File: tb/tb_dma_seq.sv
// ============================================================================
// tb_dma_seq : scoreboard bench for dma_seq (handshake addresses queued at start)
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dma_seq;
  import dma_seq_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             i_start_ld, i_start_st;
  logic [CPU_W-1:0] i_sa_ld, i_dnum_ld, i_sa_st, i_dnum_st;
  logic             i_ld_gnt, i_st_gnt;
  logic             o_ld_req, o_st_req, o_ld_done, o_st_done, o_busy;
  logic [CPU_W-1:0] o_ld_addr, o_st_addr;
`ifdef DMA_STRIDE_EN
  logic [CPU_W-1:0] i_stride_ld, i_stride_st;
`endif

  int checks   = 0;
  int failures = 0;
  int ld_hs = 0, st_hs = 0, ld_done_cnt = 0, st_done_cnt = 0;
  logic [CPU_W-1:0] ld_exp[$];
  logic [CPU_W-1:0] st_exp[$];
  logic [CPU_W-1:0] mon_exp;

  always #5 clk = ~clk;

  dma_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start_ld (i_start_ld),
    .i_sa_ld    (i_sa_ld),
    .i_dnum_ld  (i_dnum_ld),
    .i_start_st (i_start_st),
    .i_sa_st    (i_sa_st),
    .i_dnum_st  (i_dnum_st),
    .o_ld_req   (o_ld_req),
    .o_ld_addr  (o_ld_addr),
    .i_ld_gnt   (i_ld_gnt),
    .o_st_req   (o_st_req),
    .o_st_addr  (o_st_addr),
    .i_st_gnt   (i_st_gnt),
    .o_ld_done  (o_ld_done),
    .o_st_done  (o_st_done),
`ifdef DMA_STRIDE_EN
    .i_stride_ld(i_stride_ld),
    .i_stride_st(i_stride_st),
`endif
    .o_busy     (o_busy)
  );

  // Scoreboard: every accepted request must match the next queued address.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (o_ld_req === 1'b1 && i_ld_gnt === 1'b1) begin
        ld_hs++;
        checks++;
        if (ld_exp.size() == 0) begin
          failures++;
          $display("FAIL ld_scoreboard: unexpected handshake addr=%h, none expected", o_ld_addr);
        end else begin
          mon_exp = ld_exp.pop_front();
          if (o_ld_addr !== mon_exp) begin
            failures++;
            $display("FAIL ld_scoreboard: addr=%h expected=%h", o_ld_addr, mon_exp);
          end
        end
      end
      if (o_st_req === 1'b1 && i_st_gnt === 1'b1) begin
        st_hs++;
        checks++;
        if (st_exp.size() == 0) begin
          failures++;
          $display("FAIL st_scoreboard: unexpected handshake addr=%h, none expected", o_st_addr);
        end else begin
          mon_exp = st_exp.pop_front();
          if (o_st_addr !== mon_exp) begin
            failures++;
            $display("FAIL st_scoreboard: addr=%h expected=%h", o_st_addr, mon_exp);
          end
        end
      end
    end
    if (o_ld_done === 1'b1) ld_done_cnt++;
    if (o_st_done === 1'b1) st_done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({o_ld_req, o_st_req, o_ld_done, o_st_done, o_busy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: got=%b expected=00000",
               {o_ld_req, o_st_req, o_ld_done, o_st_done, o_busy});
    end
    checks++;
    if (o_ld_addr !== '0 || o_st_addr !== '0) begin
      failures++;
      $display("FAIL reset_addr: ld=%h st=%h expected=0000", o_ld_addr, o_st_addr);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (o_busy !== 1'b0 || o_ld_req !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: busy=%b req=%b expected 0 0", o_busy, o_ld_req);
    end
  endtask

  task automatic test_load_basic();
    i_ld_gnt = 1'b1;
    for (int k = 0; k < 4; k++) ld_exp.push_back(CPU_W'(16'h0100 + k));
    i_sa_ld = 16'h0100; i_dnum_ld = 16'd4; i_start_ld = 1'b1;
    tick();
    i_start_ld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (o_ld_req !== 1'b1 || o_busy !== 1'b1 || o_ld_done !== 1'b0 ||
          o_ld_addr !== CPU_W'(16'h0100 + k)) begin
        failures++;
        $display("FAIL load_run[%0d]: req=%b busy=%b done=%b addr=%h expected 1 1 0 %h",
                 k, o_ld_req, o_busy, o_ld_done, o_ld_addr, CPU_W'(16'h0100 + k));
      end
      tick();
    end
    checks++;
    if (o_ld_done !== 1'b1 || o_ld_req !== 1'b0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL load_done: done=%b req=%b busy=%b expected 1 0 0", o_ld_done, o_ld_req, o_busy);
    end
    tick();
    checks++;
    if (o_ld_done !== 1'b0 || ld_exp.size() != 0) begin
      failures++;
      $display("FAIL load_after: done=%b pending=%0d expected 0 0", o_ld_done, ld_exp.size());
    end
    i_ld_gnt = 1'b0;
  endtask

  task automatic test_store_gnt_alt();
    int  hs0;
    bit  done_seen;
    hs0 = st_hs;
    done_seen = 1'b0;
    i_st_gnt = 1'b0;
    for (int k = 0; k < 3; k++) st_exp.push_back(CPU_W'(16'h0200 + k));
    i_sa_st = 16'h0200; i_dnum_st = 16'd3; i_start_st = 1'b1;
    tick();
    i_start_st = 1'b0;
    for (int c = 0; c < 20 && !done_seen; c++) begin
      if (o_st_done === 1'b1) begin
        done_seen = 1'b1;
      end else begin
        i_st_gnt = c[0];
        if (c < 2) begin
          checks++;
          if (o_st_req !== 1'b1 || o_st_addr !== 16'h0200) begin
            failures++;
            $display("FAIL store_hold[%0d]: req=%b addr=%h expected 1 0200", c, o_st_req, o_st_addr);
          end
        end
        tick();
      end
    end
    i_st_gnt = 1'b0;
    checks++;
    if (!done_seen || (st_hs - hs0) != 3 || st_exp.size() != 0) begin
      failures++;
      $display("FAIL store_alt: done_seen=%0d handshakes=%0d pending=%0d expected 1 3 0",
               done_seen, st_hs - hs0, st_exp.size());
    end
    tick();
    checks++;
    if (o_st_done !== 1'b0) begin
      failures++;
      $display("FAIL store_done_width: done=%b expected 0", o_st_done);
    end
  endtask

  task automatic test_zero_restart();
    i_ld_gnt = 1'b1;
    i_sa_ld = 16'h0300; i_dnum_ld = 16'd0; i_start_ld = 1'b1;
    tick();
    i_start_ld = 1'b0;
    checks++;
    if (o_ld_done !== 1'b1 || o_ld_req !== 1'b0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_done: done=%b req=%b busy=%b expected 1 0 0", o_ld_done, o_ld_req, o_busy);
    end
    ld_exp.push_back(16'h0300);
    ld_exp.push_back(16'h0301);
    i_dnum_ld = 16'd2; i_start_ld = 1'b1;
    tick();
    i_start_ld = 1'b0;
    checks++;
    if (o_ld_req !== 1'b1 || o_ld_addr !== 16'h0300 || o_ld_done !== 1'b0) begin
      failures++;
      $display("FAIL restart_run: req=%b addr=%h done=%b expected 1 0300 0", o_ld_req, o_ld_addr, o_ld_done);
    end
    tick();
    checks++;
    if (o_ld_addr !== 16'h0301) begin
      failures++;
      $display("FAIL restart_addr: addr=%h expected 0301", o_ld_addr);
    end
    tick();
    checks++;
    if (o_ld_done !== 1'b1 || o_ld_req !== 1'b0) begin
      failures++;
      $display("FAIL restart_done: done=%b req=%b expected 1 0", o_ld_done, o_ld_req);
    end
    tick();
    i_ld_gnt = 1'b0;
  endtask

  task automatic test_wrap_ignore();
    logic [CPU_W-1:0] exp_a[3];
    exp_a[0] = 16'hFFFE; exp_a[1] = 16'hFFFF; exp_a[2] = 16'h0000;
    i_ld_gnt = 1'b1;
    for (int k = 0; k < 3; k++) ld_exp.push_back(exp_a[k]);
    i_sa_ld = 16'hFFFE; i_dnum_ld = 16'd3; i_start_ld = 1'b1;
    tick();
    i_sa_ld = 16'h1234; i_dnum_ld = 16'd5;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (o_ld_req !== 1'b1 || o_ld_addr !== exp_a[k]) begin
        failures++;
        $display("FAIL wrap[%0d]: req=%b addr=%h expected 1 %h", k, o_ld_req, o_ld_addr, exp_a[k]);
      end
      tick();
      i_start_ld = 1'b0;
    end
    checks++;
    if (o_ld_done !== 1'b1 || o_ld_req !== 1'b0) begin
      failures++;
      $display("FAIL wrap_done: done=%b req=%b expected 1 0", o_ld_done, o_ld_req);
    end
    tick();
    checks++;
    if (o_ld_req !== 1'b0 || ld_exp.size() != 0) begin
      failures++;
      $display("FAIL ignore_start: req=%b pending=%0d expected 0 0", o_ld_req, ld_exp.size());
    end
    i_ld_gnt = 1'b0;
  endtask

  task automatic test_concurrent_reset();
    int d_ld, d_st;
    i_ld_gnt = 1'b1; i_st_gnt = 1'b1;
    ld_exp.push_back(16'h0400); ld_exp.push_back(16'h0401);
    st_exp.push_back(16'h0500); st_exp.push_back(16'h0501);
    i_sa_ld = 16'h0400; i_dnum_ld = 16'd8;
    i_sa_st = 16'h0500; i_dnum_st = 16'd8;
    i_start_ld = 1'b1; i_start_st = 1'b1;
    tick();
    i_start_ld = 1'b0; i_start_st = 1'b0;
    checks++;
    if (o_ld_req !== 1'b1 || o_st_req !== 1'b1 || o_ld_addr !== 16'h0400 || o_st_addr !== 16'h0500) begin
      failures++;
      $display("FAIL both_start: ldreq=%b streq=%b ld=%h st=%h expected 1 1 0400 0500",
               o_ld_req, o_st_req, o_ld_addr, o_st_addr);
    end
    tick();
    tick();
    d_ld = ld_done_cnt; d_st = st_done_cnt;
    rst_n = 1'b0;
    tick();
    checks++;
    if ({o_ld_req, o_st_req, o_ld_done, o_st_done, o_busy} !== 5'b0 ||
        o_ld_addr !== '0 || o_st_addr !== '0) begin
      failures++;
      $display("FAIL midrun_reset: flags=%b ld=%h st=%h expected 00000 0000 0000",
               {o_ld_req, o_st_req, o_ld_done, o_st_done, o_busy}, o_ld_addr, o_st_addr);
    end
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    checks++;
    if (ld_done_cnt != d_ld || st_done_cnt != d_st || o_ld_req !== 1'b0 || o_st_req !== 1'b0 ||
        ld_exp.size() != 0 || st_exp.size() != 0) begin
      failures++;
      $display("FAIL abort: ld_done=%0d st_done=%0d req=%b%b pending=%0d/%0d expected 0 0 00 0/0",
               ld_done_cnt - d_ld, st_done_cnt - d_st, o_ld_req, o_st_req,
               ld_exp.size(), st_exp.size());
    end
    i_ld_gnt = 1'b0; i_st_gnt = 1'b0;
  endtask

`ifdef DMA_STRIDE_EN
  task automatic test_stride();
    i_ld_gnt = 1'b1;
    i_stride_ld = 16'd4;
    for (int k = 0; k < 3; k++) ld_exp.push_back(CPU_W'(16'h0010 + 4 * k));
    i_sa_ld = 16'h0010; i_dnum_ld = 16'd3; i_start_ld = 1'b1;
    tick();
    i_start_ld = 1'b0;
    i_stride_ld = 16'd1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (o_ld_addr !== CPU_W'(16'h0010 + 4 * k)) begin
        failures++;
        $display("FAIL stride[%0d]: addr=%h expected %h", k, o_ld_addr, CPU_W'(16'h0010 + 4 * k));
      end
      tick();
    end
    checks++;
    if (o_ld_done !== 1'b1 || ld_exp.size() != 0) begin
      failures++;
      $display("FAIL stride_done: done=%b pending=%0d expected 1 0", o_ld_done, ld_exp.size());
    end
    tick();
    i_ld_gnt = 1'b0;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    i_start_ld = 1'b0; i_start_st = 1'b0;
    i_sa_ld = '0; i_dnum_ld = '0; i_sa_st = '0; i_dnum_st = '0;
    i_ld_gnt = 1'b0; i_st_gnt = 1'b0;
`ifdef DMA_STRIDE_EN
    i_stride_ld = 16'd1; i_stride_st = 16'd1;
`endif
    test_reset();
    test_load_basic();
    test_store_gnt_alt();
    test_zero_restart();
    test_wrap_ignore();
    test_concurrent_reset();
`ifdef DMA_STRIDE_EN
    test_stride();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dma_seq.md
# dma_seq

Load/store address sequencer that consumes the start-address and data-count values the CPU writes into its load/store special registers. The CPU pulses a start strobe per channel; the block latches the operands and walks a contiguous (or strided) address range with a req/gnt handshake toward the data memory, then pulses done. Load and store channels run independently and concurrently. The block sits between the CPU register file and the array data-memory port.

## Interface
- Parameters: none; all widths come from `CPU_W` in SMA.h.
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- i_start_ld  in  1  one-cycle pulse: start load sequence
- i_sa_ld  in  CPU_W  load start address
- i_dnum_ld  in  CPU_W  load word count
- i_start_st  in  1  one-cycle pulse: start store sequence
- i_sa_st  in  CPU_W  store start address
- i_dnum_st  in  CPU_W  store word count
- o_ld_req  out  1  load request valid
- o_ld_addr  out  CPU_W  load address
- i_ld_gnt  in  1  load request accepted
- o_st_req  out  1  store request valid
- o_st_addr  out  CPU_W  store address
- i_st_gnt  in  1  store request accepted
- o_ld_done  out  1  one-cycle pulse: load sequence finished
- o_st_done  out  1  one-cycle pulse: store sequence finished
- o_busy  out  1  OR of both channels' busy
- DMA_STRIDE_EN only: i_stride_ld, i_stride_st  in  CPU_W  address increment

## Operation
- Per channel FSM: IDLE -> RUN -> DONE -> IDLE.
- IDLE/DONE: start pulse latches sa into addr register, dnum into count register, stride (if enabled) into stride register; next state RUN, or DONE directly if dnum == 0.
- Start while RUN: ignored; no operand latch, no effect on sequence in flight.
- RUN: o_req = 1, o_addr = addr register; address held stable until gnt.
- Handshake on req & gnt: addr <= addr + stride (stride = 1 without macro); count <= count - 1; if count was 1 -> DONE.
- gnt without req: ignored.
- DONE: o_done = 1 for exactly one cycle, req low; next IDLE unless a start is present that cycle.
- Address arithmetic modulo 2^CPU_W; 0xFFFF + 1 wraps to 0x0000 (CPU_W=16).
- Operands are latched; later writes to the source registers do not affect a running sequence.
- Channels share nothing; simultaneous start_ld and start_st both accepted.
- Reset values: o_ld_req, o_st_req, o_ld_done, o_st_done, o_busy = 0; o_ld_addr, o_st_addr = 0; counts = 0; FSMs IDLE.
- Reset mid-sequence: abort at once, no done pulse, no further requests.

## Timing
- Start sampled at edge N: o_req = 1 with addr = sa from cycle N+1.
- With gnt tied high: one address per cycle, dnum handshakes in cycles N+1..N+dnum, o_done in cycle N+dnum+1.
- dnum == 0: o_done in cycle N+1, no req ever asserted.
- o_busy = 1 exactly in RUN cycles of either channel; 0 in DONE.
- Back-to-back: start in the DONE cycle -> RUN next cycle; done and new start coexist without loss.

## Configuration
- DMA_STRIDE_EN defined: i_stride_ld / i_stride_st ports exist; stride latched at start, added per handshake modulo 2^CPU_W; stride 0 repeats the same address dnum times.
- Undefined: ports absent, increment fixed at 1.

## Structure
- SMA.h holds `CPU_W` and the FSM state encodings (`DMA_IDLE`, `DMA_RUN`, `DMA_DONE`).
- One sub-module dma_chan (FSM, addr/count/stride registers, req/done logic), instantiated twice; dma_seq adds the port mapping and o_busy OR.

## Test plan
- Load sa=0x0100, dnum=4, gnt high -> addrs 0x0100..0x0103 in cycles N+1..N+4, o_ld_done at N+5, o_busy high N+1..N+4.
- Store sa=0x0200, dnum=3, gnt high only every other cycle -> 0x0200 held until first gnt, exactly 3 handshakes, then done pulse.
- dnum=0 on load -> no o_ld_req, o_ld_done at N+1; restart in done cycle with dnum=2 -> RUN next cycle.
- sa=0xFFFE, dnum=3 -> addrs 0xFFFE, 0xFFFF, 0x0000; second start during RUN ignored.
- Both channels started same cycle, rst_n low mid-run -> all outputs 0 next cycle, no done pulses.
- DMA_STRIDE_EN, stride=4, sa=0x0010, dnum=3 -> 0x0010, 0x0014, 0x0018.
